// File: rtl/mult_seq_param_if.sv
// Start/operand/result bundle for mult_seq_param.
// signed_op exists only when MULT_SIGNED_EN is defined.
interface mult_seq_param_if #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 32
);
    logic                       start;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
`ifdef MULT_SIGNED_EN
    logic                       signed_op;
`endif
    logic                       busy;
    logic                       done;
    logic [A_WIDTH+B_WIDTH-1:0] product;

    modport master (
`ifdef MULT_SIGNED_EN
        output signed_op,
`endif
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
`ifdef MULT_SIGNED_EN
        input  signed_op,
`endif
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_seq_param.sv
// Sequential chunked multiplier: one A_CHUNK x B_CHUNK partial product per cycle.
// Optional two's-complement support (extra FIX state) is enabled by defining MULT_SIGNED_EN.
module mult_seq_param #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 32,
    parameter int unsigned A_CHUNK = 8,
    parameter int unsigned B_CHUNK = 16
) (
    input logic            clk,
    input logic            reset_n,
    mult_seq_param_if.slave bus
);

    localparam int unsigned PW  = A_WIDTH + B_WIDTH;
    localparam int unsigned PPW = A_CHUNK + B_CHUNK;
    localparam int unsigned NA  = A_WIDTH / A_CHUNK;
    localparam int unsigned NB  = B_WIDTH / B_CHUNK;
    localparam int unsigned IW  = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned JW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned SW  = $clog2(PW) + 1;

`ifdef MULT_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
`else
    typedef enum logic {IDLE, RUN} state_e;
`endif

    state_e             state_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [IW-1:0]      i_q;
    logic [JW-1:0]      j_q;
    logic [PW-1:0]      product_q;
    logic               busy_q;
    logic               done_q;
`ifdef MULT_SIGNED_EN
    logic               signed_q;
    logic               sign_q;
    logic [A_WIDTH-1:0] a_mag_c;
    logic [B_WIDTH-1:0] b_mag_c;
`endif

    logic [A_CHUNK-1:0] a_chunk_c;
    logic [B_CHUNK-1:0] b_chunk_c;
    logic [PPW-1:0]     pp_c;
    logic [SW-1:0]      shamt_c;
    logic [PW-1:0]      pp_shifted_c;
    logic               last_c;
    logic               i_wrap_c;

    // Current partial product, zero-extended and aligned to its chunk position
    always_comb begin
        a_chunk_c    = A_CHUNK'(a_q >> (32'(i_q) * A_CHUNK));
        b_chunk_c    = B_CHUNK'(b_q >> (32'(j_q) * B_CHUNK));
        pp_c         = PPW'(a_chunk_c) * PPW'(b_chunk_c);
        shamt_c      = SW'(32'(i_q) * A_CHUNK + 32'(j_q) * B_CHUNK);
        pp_shifted_c = PW'(pp_c) << shamt_c;
        i_wrap_c     = (i_q == IW'(NA - 1));
        last_c       = i_wrap_c && (j_q == JW'(NB - 1));
    end

`ifdef MULT_SIGNED_EN
    // Magnitudes; the most negative value maps naturally to 2^(W-1)
    always_comb begin
        a_mag_c = bus.a[A_WIDTH-1] ? A_WIDTH'(-bus.a) : bus.a;
        b_mag_c = bus.b[B_WIDTH-1] ? B_WIDTH'(-bus.b) : bus.b;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
`ifdef MULT_SIGNED_EN
                        if (bus.signed_op) begin
                            a_q <= a_mag_c;
                            b_q <= b_mag_c;
                        end else begin
                            a_q <= bus.a;
                            b_q <= bus.b;
                        end
                        signed_q <= bus.signed_op;
                        sign_q   <= bus.signed_op & (bus.a[A_WIDTH-1] ^ bus.b[B_WIDTH-1]);
`else
                        a_q <= bus.a;
                        b_q <= bus.b;
`endif
                        product_q <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    product_q <= product_q + pp_shifted_c;
                    if (last_c) begin
                        i_q <= '0;
                        j_q <= '0;
`ifdef MULT_SIGNED_EN
                        if (signed_q) begin
                            state_q <= FIX;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else if (i_wrap_c) begin
                        i_q <= '0;
                        j_q <= j_q + JW'(1);
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
`ifdef MULT_SIGNED_EN
                // Apply the recorded sign to the unsigned magnitude product
                FIX: begin
                    if (sign_q) begin
                        product_q <= -product_q;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
